// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg: baud divisors for a 12 MHz clock and the transmitter FSM states.
// Defining UART_TX_PARITY_EN adds the S_PARITY state.
package uart_tx_fifo_pkg;
  localparam int B115200 = 104;
  localparam int B57600  = 208;
  localparam int B38400  = 313;
  localparam int B19200  = 625;
  localparam int B9600   = 1250;
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;
endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// sync_fifo: show-ahead FIFO with registered count; pushes while full are dropped.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  input  logic             push,
  output logic [WIDTH-1:0] dout,
  input  logic             pop,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [DEPTH_LOG2:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full    = cnt_q == (DEPTH_LOG2 + 1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rptr_q];
  always_comb cnt_d = cnt_q + (DEPTH_LOG2 + 1)'(do_push) - (DEPTH_LOG2 + 1)'(do_pop);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_q + DEPTH_LOG2'(do_push);
      rptr_q <= rptr_q + DEPTH_LOG2'(do_pop);
      cnt_q  <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter with a registered tx pad.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int BAUD       = 104,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] data,
  input  logic       wr,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       tx
);
  localparam int CW = $clog2(BAUD);
  localparam logic [CW-1:0] LAST = CW'(BAUD - 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, head;
  logic [2:0] idx_q, idx_d;
  logic tx_q, tx_d, pop, last;
  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .din  (data),
    .push (wr),
    .dout (head),
    .pop  (pop),
    .full (full),
    .empty(empty)
  );
  assign last  = cnt_q == LAST;
  assign cnt_d = (state_q == S_IDLE || last) ? '0 : cnt_q + CW'(1);
  assign busy  = (state_q != S_IDLE) | ~empty;
  assign tx    = tx_q;
`ifdef UART_TX_PARITY_EN
  logic par_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) par_q <= 1'b0;
    else       par_q <= pop ? ^head : par_q;
  end
`endif
  // tx_d is the level for the state being entered, so the pad changes on the transition edge
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: if (!empty) begin
        pop     = 1'b1;
        shift_d = head;
        state_d = S_START;
        tx_d    = 1'b0;
      end
      S_START: if (last) begin
        state_d = S_DATA;
        idx_d   = 3'd0;
        tx_d    = shift_q[0];
      end
      S_DATA: if (last) begin
        shift_d = shift_q >> 1;
        idx_d   = idx_q + 3'd1;
        tx_d    = shift_q[1];
        if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
          tx_d    = par_q;
`else
          state_d = S_STOP;
          tx_d    = 1'b1;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (last) begin
        state_d = S_STOP;
        tx_d    = 1'b1;
      end
`endif
      S_STOP: if (last) begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = S_START;
          tx_d    = 1'b0;
        end else begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench; a bench-side receiver decodes tx and checks bytes and timing.
module tb_uart_tx_fifo;
  localparam int BAUD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * BAUD;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic wr = 1'b0;
  logic [7:0] data = 8'h00;
  logic full, empty, busy, tx;
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic [7:0] sb[$];
  uart_tx_fifo #(.BAUD(BAUD), .DEPTH_LOG2(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .data (data),
    .wr   (wr),
    .full (full),
    .empty(empty),
    .busy (busy),
    .tx   (tx)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic rx_frame(input int lim, output logic [7:0] b, output int t0, output bit found, output bit good);
    int n;
    n = 0;
    b = '0;
    t0 = 0;
    found = 0;
    good = 0;
    while (tx !== 1'b0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) return;
    found = 1;
    t0 = cyc;
    repeat (BAUD / 2) @(negedge clk);
    good = (tx === 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (BAUD) @(negedge clk);
      b[i] = tx;
    end
`ifdef UART_TX_PARITY_EN
    repeat (BAUD) @(negedge clk);
    good &= (tx === ^b);
`endif
    repeat (BAUD) @(negedge clk);
    good &= (tx === 1'b1);
  endtask
  task automatic test_reset();
    rstn = 1'b0;
    repeat (20) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      compared++;
      if (tx !== 1'b1) begin mismatched++; $display("FAIL reset_tx: cycle %0d got %b expected 1", i, tx); end
      compared++;
      if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: cycle %0d got %b expected 0", i, busy); end
      compared++;
      if (empty !== 1'b1) begin mismatched++; $display("FAIL reset_empty: cycle %0d got %b expected 1", i, empty); end
      compared++;
      if (full !== 1'b0) begin mismatched++; $display("FAIL reset_full: cycle %0d got %b expected 0", i, full); end
    end
  endtask
  task automatic test_single();
    logic [NB-1:0] line;
    logic [7:0] b, exp_b;
    int lat;
    line = '1;
    line[0] = 1'b0;
    line[8:1] = 8'h31;
`ifdef UART_TX_PARITY_EN
    line[9] = ^line[8:1];
`endif
    b = '0;
    @(negedge clk);
    data = 8'h31;
    wr = 1'b1;
    sb.push_back(8'h31);
    @(negedge clk);
    wr = 1'b0;
    lat = 1;
    while (tx !== 1'b0 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    compared++;
    if (lat !== 2) begin mismatched++; $display("FAIL single_latency: got %0d cycles expected 2", lat); end
    for (int i = 0; i < FL; i++) begin
      compared++;
      if (tx !== line[i / BAUD]) begin mismatched++; $display("FAIL single_line: sample %0d got %b expected %b", i, tx, line[i / BAUD]); end
      if (i % BAUD == BAUD / 2 && i / BAUD >= 1 && i / BAUD <= 8) b[i / BAUD - 1] = tx;
      if (i == FL - 1) begin
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("FAIL single_busy_last: got %b expected 1", busy); end
      end
      @(negedge clk);
    end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL single_busy_end: got %b expected 0", busy); end
    exp_b = sb.pop_front();
    compared++;
    if (b !== exp_b) begin mismatched++; $display("FAIL single_decode: got %h expected %h", b, exp_b); end
  endtask
  task automatic test_back_to_back();
    logic [7:0] v[4];
    int first, prev, n;
    v = '{8'h31, 8'h30, 8'h0A, 8'h04};
    first = 0;
    prev = 0;
    fork
      for (int i = 0; i < 4; i++) begin
        data = v[i];
        wr = 1'b1;
        sb.push_back(v[i]);
        @(negedge clk);
        wr = 1'b0;
        compared++;
        if (full !== 1'b0) begin mismatched++; $display("FAIL b2b_full: push %0d got %b expected 0", i, full); end
      end
      for (int i = 0; i < 4; i++) begin
        logic [7:0] b, e;
        int t0;
        bit fnd, good;
        rx_frame(3 * FL, b, t0, fnd, good);
        e = sb.pop_front();
        compared++;
        if (!fnd || !good || b !== e) begin mismatched++; $display("FAIL b2b_frame: frame %0d got %h (found %0d framing %0d) expected %h", i, b, fnd, good, e); end
        if (i == 0) first = t0;
        else begin
          compared++;
          if (t0 - prev !== FL) begin mismatched++; $display("FAIL b2b_gap: frame %0d spacing %0d expected %0d", i, t0 - prev, FL); end
        end
        prev = t0;
      end
    join
    n = 0;
    while (busy !== 1'b0 && n < FL) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (cyc - first !== 4 * FL) begin mismatched++; $display("FAIL b2b_total: got %0d cycles expected %0d", cyc - first, 4 * FL); end
  endtask
  task automatic test_overflow();
    logic [7:0] b;
    int t0;
    bit fnd, good;
    fork
      for (int i = 0; i < 6; i++) begin
        data = 8'(i + 1);
        wr = 1'b1;
        if (i < 5) sb.push_back(8'(i + 1));
        @(negedge clk);
        wr = 1'b0;
        compared++;
        if (full !== (i >= 4)) begin mismatched++; $display("FAIL ovf_full: push %0d got %b expected %b", i + 1, full, i >= 4); end
      end
      for (int i = 0; i < 5; i++) begin
        logic [7:0] rb, e;
        int rt;
        bit rf, rg;
        rx_frame(3 * FL, rb, rt, rf, rg);
        e = sb.pop_front();
        compared++;
        if (!rf || !rg || rb !== e) begin mismatched++; $display("FAIL ovf_frame: frame %0d got %h (found %0d framing %0d) expected %h", i, rb, rf, rg, e); end
      end
    join
    rx_frame(2 * FL, b, t0, fnd, good);
    compared++;
    if (fnd !== 1'b0) begin mismatched++; $display("FAIL ovf_extra: got extra frame %h expected none", b); end
    compared++;
    if (empty !== 1'b1) begin mismatched++; $display("FAIL ovf_empty: got %b expected 1", empty); end
  endtask
  task automatic test_reset_mid_frame();
    logic [7:0] b;
    int t0, n;
    bit fnd, good;
    fork
      begin
        logic [7:0] v[3];
        v = '{8'h55, 8'hAA, 8'h0F};
        for (int i = 0; i < 3; i++) begin
          data = v[i];
          wr = 1'b1;
          sb.push_back(v[i]);
          @(negedge clk);
          wr = 1'b0;
        end
      end
      begin
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
          @(negedge clk);
          n++;
        end
        repeat (BAUD / 2 + 4 * BAUD) @(negedge clk);
      end
    join
    compared++;
    if (tx !== 1'b0) begin mismatched++; $display("FAIL rmf_bit3: got %b expected 0", tx); end
    compared++;
    if (empty !== 1'b0) begin mismatched++; $display("FAIL rmf_queued: empty got %b expected 0", empty); end
    rstn = 1'b0;
    sb.delete();
    #1;
    compared++;
    if (tx !== 1'b1) begin mismatched++; $display("FAIL rmf_tx_async: got %b expected 1", tx); end
    compared++;
    if (empty !== 1'b1) begin mismatched++; $display("FAIL rmf_empty: got %b expected 1", empty); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL rmf_busy: got %b expected 0", busy); end
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    rx_frame(100, b, t0, fnd, good);
    compared++;
    if (fnd !== 1'b0) begin mismatched++; $display("FAIL rmf_no_frame: got frame %h expected none", b); end
    compared++;
    if (empty !== 1'b1) begin mismatched++; $display("FAIL rmf_empty_after: got %b expected 1", empty); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
